// File: rtl/fetch_if.sv
// Fetch-unit bus: instruction-memory request/response, redirect input and
// the instruction handshake towards decode.
interface fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    // master: the fetch unit itself
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata,
        input  redirect,
        input  redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc
    );

    // slave: instruction memory plus the downstream pipeline
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata,
        output redirect,
        output redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc
    );
endinterface

// File: rtl/fetch.sv
// Instruction fetch: credit-limited requests into a 2-entry FIFO, redirect/drop.
// FETCH_ALIGN_CHECK_EN adds the sticky fetch_misaligned output and fetch stall.
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic    clk,
    input  logic    rst,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic    fetch_misaligned,
`endif
    fetch_if.master bus
);

    localparam int DEPTH = 2;

    logic [31:0] pc_reg;
    logic [1:0]  count_reg;
    logic [1:0]  count_next;
    logic        rd_ptr_reg;
    logic        wr_ptr_reg;
    logic        inflight_reg;
    logic [31:0] inflight_pc_reg;
    logic        drop_reg;
    logic [31:0] word_reg [DEPTH];
    logic [31:0] wpc_reg  [DEPTH];

    logic        halt;
    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  occupancy;
    logic [31:0] redirect_target;

    assign redirect_target = {bus.redirect_pc[31:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned_reg;

    assign halt             = misaligned_reg;
    assign fetch_misaligned = misaligned_reg;

    // Sticky until the next redirect re-evaluates alignment, or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            misaligned_reg <= 1'b0;
        end else if (bus.redirect) begin
            misaligned_reg <= |bus.redirect_pc[1:0];
        end
    end
`else
    logic unused_redirect_lsb;

    assign halt                = 1'b0;
    assign unused_redirect_lsb = ^bus.redirect_pc[1:0];
`endif

    // Decode-side view of the FIFO head
    assign bus.instr_valid = !rst && (count_reg != 2'd0);
    assign bus.instr       = word_reg[rd_ptr_reg];
    assign bus.instr_pc    = wpc_reg[rd_ptr_reg];

    assign pop = bus.instr_valid && bus.instr_ready && !bus.redirect;

    // Buffered plus outstanding instructions after this cycle's pop must leave
    // a free slot, so every response always finds room in the FIFO.
    assign occupancy = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    assign issue     = !rst && !bus.redirect && !halt && (occupancy < 3'd2);

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc_reg;

    // A response is only taken when it answers our own surviving request.
    assign push = bus.imem_rvalid && inflight_reg && !drop_reg && !bus.redirect && !rst;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg       <= RESET_PC;
            count_reg    <= 2'd0;
            rd_ptr_reg   <= 1'b0;
            wr_ptr_reg   <= 1'b0;
            inflight_reg <= 1'b0;
            drop_reg     <= 1'b0;
        end else if (bus.redirect) begin
            pc_reg       <= redirect_target;
            count_reg    <= 2'd0;
            rd_ptr_reg   <= 1'b0;
            wr_ptr_reg   <= 1'b0;
            inflight_reg <= 1'b0;
            drop_reg     <= inflight_reg;
        end else begin
            if (issue) begin
                pc_reg <= pc_reg + 32'd4;
            end
            inflight_reg <= issue;
            drop_reg     <= 1'b0;
            count_reg    <= count_next;
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
        end
    end

    // Datapath registers carry no reset; validity lives in count/inflight.
    always_ff @(posedge clk) begin
        if (issue) begin
            inflight_pc_reg <= pc_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == 1'(gi))) begin
                    word_reg[gi] <= bus.imem_rdata;
                    wpc_reg[gi]  <= inflight_pc_reg;
                end
            end
        end
    endgenerate

    assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count_reg == 2'd2)));

endmodule
